// File: rtl/pico_axi_arb_pkg.sv
// Shared types for the AXI write/read arbiter: FSM state encoding and WQ sizing helpers.
package pico_axi_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Occupancy counter needs one extra bit to represent "full".
  function automatic int wq_cnt_w(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/pico_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, as one-hot and index.
module pico_rr_arbiter #(
  parameter int N     = 4,
  parameter int LOG_N = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [LOG_N-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [LOG_N-1:0] o_idx,
  output logic             o_any
);

  logic [LOG_N-1:0] w_k;
  logic             w_found;

  // N is a power of two, so the index sum wraps naturally.
  always_comb begin
    o_grant = '0;
    o_idx   = i_ptr;
    w_found = 1'b0;
    w_k     = i_ptr;
    for (int i = 0; i < N; i++) begin
      w_k = i_ptr + LOG_N'(i);
      if (!w_found && i_req[w_k]) begin
        w_found = 1'b1;
        o_idx   = w_k;
      end
    end
    o_grant[o_idx] = w_found;
    o_any          = w_found;
  end

endmodule

// File: rtl/pico_axi_write_read_arbiter.sv
// Round-robin AW/AR arbiter onto one AXI4 master port; W follows AW grant order via a small FIFO.
// Optional PICO_ARB_ID_TAG_EN: upper ID bits of m_axi_awid/arid carry the grant index.
module pico_axi_write_read_arbiter
  import pico_axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS      = 4,
  parameter int LOG_NUM_MASTERS  = 2,
  parameter int C_AXI_ID_WIDTH   = 8,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int WQ_DEPTH         = 4,
  parameter int LOG_WQ_DEPTH     = 2
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic [NUM_MASTERS-1:0]                     s_axi_awvalid,
  output logic [NUM_MASTERS-1:0]                     s_axi_awready,
  input  logic [NUM_MASTERS*C_AXI_ID_WIDTH-1:0]      s_axi_awid,
  input  logic [NUM_MASTERS*C_AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic [NUM_MASTERS*8-1:0]                   s_axi_awlen,
  input  logic [NUM_MASTERS*3-1:0]                   s_axi_awsize,
  input  logic [NUM_MASTERS*2-1:0]                   s_axi_awburst,
  input  logic [NUM_MASTERS*C_AXI_DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [NUM_MASTERS*C_AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic [NUM_MASTERS-1:0]                     s_axi_wlast,
  input  logic [NUM_MASTERS-1:0]                     s_axi_wvalid,
  output logic [NUM_MASTERS-1:0]                     s_axi_wready,
  input  logic [NUM_MASTERS-1:0]                     s_axi_arvalid,
  output logic [NUM_MASTERS-1:0]                     s_axi_arready,
  input  logic [NUM_MASTERS*C_AXI_ID_WIDTH-1:0]      s_axi_arid,
  input  logic [NUM_MASTERS*C_AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [NUM_MASTERS*8-1:0]                   s_axi_arlen,
  input  logic [NUM_MASTERS*3-1:0]                   s_axi_arsize,
  input  logic [NUM_MASTERS*2-1:0]                   s_axi_arburst,
  output logic                                       m_axi_awvalid,
  input  logic                                       m_axi_awready,
  output logic [C_AXI_ID_WIDTH-1:0]                  m_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0]                m_axi_awaddr,
  output logic [7:0]                                 m_axi_awlen,
  output logic [2:0]                                 m_axi_awsize,
  output logic [1:0]                                 m_axi_awburst,
  output logic [C_AXI_DATA_WIDTH-1:0]                m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]              m_axi_wstrb,
  output logic                                       m_axi_wlast,
  output logic                                       m_axi_wvalid,
  input  logic                                       m_axi_wready,
  output logic                                       m_axi_arvalid,
  input  logic                                       m_axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]                  m_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [7:0]                                 m_axi_arlen,
  output logic [2:0]                                 m_axi_arsize,
  output logic [1:0]                                 m_axi_arburst
);

  localparam int N     = NUM_MASTERS;
  localparam int LN    = LOG_NUM_MASTERS;
  localparam int IW    = C_AXI_ID_WIDTH;
  localparam int AW    = C_AXI_ADDR_WIDTH;
  localparam int DW    = C_AXI_DATA_WIDTH;
  localparam int SW    = C_AXI_DATA_WIDTH / 8;
  localparam int CNT_W = wq_cnt_w(LOG_WQ_DEPTH);

  logic [IW-1:0] w_awid_a   [N];
  logic [AW-1:0] w_awaddr_a [N];
  logic [7:0]    w_awlen_a  [N];
  logic [2:0]    w_awsize_a [N];
  logic [1:0]    w_awburst_a[N];
  logic [DW-1:0] w_wdata_a  [N];
  logic [SW-1:0] w_wstrb_a  [N];
  logic [IW-1:0] w_arid_a   [N];
  logic [AW-1:0] w_araddr_a [N];
  logic [7:0]    w_arlen_a  [N];
  logic [2:0]    w_arsize_a [N];
  logic [1:0]    w_arburst_a[N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unflat
    assign w_awid_a[gi]    = s_axi_awid[gi*IW +: IW];
    assign w_awaddr_a[gi]  = s_axi_awaddr[gi*AW +: AW];
    assign w_awlen_a[gi]   = s_axi_awlen[gi*8 +: 8];
    assign w_awsize_a[gi]  = s_axi_awsize[gi*3 +: 3];
    assign w_awburst_a[gi] = s_axi_awburst[gi*2 +: 2];
    assign w_wdata_a[gi]   = s_axi_wdata[gi*DW +: DW];
    assign w_wstrb_a[gi]   = s_axi_wstrb[gi*SW +: SW];
    assign w_arid_a[gi]    = s_axi_arid[gi*IW +: IW];
    assign w_araddr_a[gi]  = s_axi_araddr[gi*AW +: AW];
    assign w_arlen_a[gi]   = s_axi_arlen[gi*8 +: 8];
    assign w_arsize_a[gi]  = s_axi_arsize[gi*3 +: 3];
    assign w_arburst_a[gi] = s_axi_arburst[gi*2 +: 2];
  end

  arb_state_t    r_aw_state, r_ar_state;
  logic [LN-1:0] r_aw_g, r_aw_ptr, r_ar_g, r_ar_ptr;
  logic [N-1:0]  r_aw_oh, r_ar_oh;
  logic [N-1:0]  w_aw_oh, w_ar_oh;
  logic [LN-1:0] w_aw_idx, w_ar_idx;
  logic          w_aw_any, w_ar_any, w_aw_hs, w_ar_hs;
  logic          w_wq_full, w_wq_empty, w_wq_pop;

  pico_rr_arbiter #(.N(N), .LOG_N(LN)) u_aw_rr (
    .i_req(s_axi_awvalid), .i_ptr(r_aw_ptr),
    .o_grant(w_aw_oh), .o_idx(w_aw_idx), .o_any(w_aw_any)
  );

  pico_rr_arbiter #(.N(N), .LOG_N(LN)) u_ar_rr (
    .i_req(s_axi_arvalid), .i_ptr(r_ar_ptr),
    .o_grant(w_ar_oh), .o_idx(w_ar_idx), .o_any(w_ar_any)
  );

  // AW grant is held until handshake; new grants wait while the W queue is full.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_aw_state <= ST_IDLE;
      r_aw_ptr   <= '0;
      r_aw_g     <= '0;
      r_aw_oh    <= '0;
    end else begin
      case (r_aw_state)
        ST_IDLE: if (w_aw_any && !w_wq_full) begin
          r_aw_g     <= w_aw_idx;
          r_aw_oh    <= w_aw_oh;
          r_aw_state <= ST_GRANT;
        end
        ST_GRANT: if (w_aw_hs) begin
          r_aw_ptr   <= r_aw_g + 1'b1;
          r_aw_oh    <= '0;
          r_aw_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ar_state <= ST_IDLE;
      r_ar_ptr   <= '0;
      r_ar_g     <= '0;
      r_ar_oh    <= '0;
    end else begin
      case (r_ar_state)
        ST_IDLE: if (w_ar_any) begin
          r_ar_g     <= w_ar_idx;
          r_ar_oh    <= w_ar_oh;
          r_ar_state <= ST_GRANT;
        end
        ST_GRANT: if (w_ar_hs) begin
          r_ar_ptr   <= r_ar_g + 1'b1;
          r_ar_oh    <= '0;
          r_ar_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axi_awvalid = (r_aw_state == ST_GRANT) && s_axi_awvalid[r_aw_g];
  assign s_axi_awready = (r_aw_state == ST_GRANT && m_axi_awready) ? r_aw_oh : '0;
  assign w_aw_hs       = m_axi_awvalid && m_axi_awready;
  assign m_axi_awaddr  = w_awaddr_a[r_aw_g];
  assign m_axi_awlen   = w_awlen_a[r_aw_g];
  assign m_axi_awsize  = w_awsize_a[r_aw_g];
  assign m_axi_awburst = w_awburst_a[r_aw_g];

  assign m_axi_arvalid = (r_ar_state == ST_GRANT) && s_axi_arvalid[r_ar_g];
  assign s_axi_arready = (r_ar_state == ST_GRANT && m_axi_arready) ? r_ar_oh : '0;
  assign w_ar_hs       = m_axi_arvalid && m_axi_arready;
  assign m_axi_araddr  = w_araddr_a[r_ar_g];
  assign m_axi_arlen   = w_arlen_a[r_ar_g];
  assign m_axi_arsize  = w_arsize_a[r_ar_g];
  assign m_axi_arburst = w_arburst_a[r_ar_g];

`ifdef PICO_ARB_ID_TAG_EN
  assign m_axi_awid = {r_aw_g, w_awid_a[r_aw_g][IW-LN-1:0]};
  assign m_axi_arid = {r_ar_g, w_arid_a[r_ar_g][IW-LN-1:0]};
`else
  assign m_axi_awid = w_awid_a[r_aw_g];
  assign m_axi_arid = w_arid_a[r_ar_g];
`endif

  // W queue: one grant index per AW accepted whose burst has not yet seen wlast.
  logic [LN-1:0]           r_wq_mem [WQ_DEPTH];
  logic [LOG_WQ_DEPTH-1:0] r_wq_wptr, r_wq_rptr;
  logic [CNT_W-1:0]        r_wq_cnt;
  logic [LN-1:0]           w_wq_head;

  assign w_wq_full  = (r_wq_cnt == CNT_W'(WQ_DEPTH));
  assign w_wq_empty = (r_wq_cnt == '0);
  assign w_wq_head  = r_wq_mem[r_wq_rptr];
  assign w_wq_pop   = m_axi_wvalid && m_axi_wready && m_axi_wlast;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wq_wptr <= '0;
      r_wq_rptr <= '0;
      r_wq_cnt  <= '0;
    end else begin
      if (w_aw_hs)  r_wq_wptr <= r_wq_wptr + 1'b1;
      if (w_wq_pop) r_wq_rptr <= r_wq_rptr + 1'b1;
      case ({w_aw_hs, w_wq_pop})
        2'b10:   r_wq_cnt <= r_wq_cnt + 1'b1;
        2'b01:   r_wq_cnt <= r_wq_cnt - 1'b1;
        default: r_wq_cnt <= r_wq_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_aw_hs) r_wq_mem[r_wq_wptr] <= r_aw_g;
  end

  assign m_axi_wvalid = !w_wq_empty && s_axi_wvalid[w_wq_head];
  assign m_axi_wdata  = w_wdata_a[w_wq_head];
  assign m_axi_wstrb  = w_wstrb_a[w_wq_head];
  assign m_axi_wlast  = s_axi_wlast[w_wq_head];

  always_comb begin
    s_axi_wready = '0;
    if (!w_wq_empty) s_axi_wready[w_wq_head] = m_axi_wready;
  end

endmodule
